// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   state_t  : controller states (IDLE, RUN, DONE)
//   NIBBLE_W : width of the carry-lookahead slice
//   clog2    : counter width helper, never returns less than 1
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..n-1. Clamped to 1 so a
    // single-nibble build still gets a legal vector.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bus of the nibble-serial adder.
//   in_valid/in_ready   : operand handshake carrying a, b, cin
//   out_valid/out_ready : result handshake carrying sum, cout, ovf
// Handshake rule (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds its payload
// and valid stable until that edge; ready may change freely.
// master = operand producer / result consumer, slave = the adder.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/nibble_serial_adder_cla4.sv
// Combinational 4-bit carry-lookahead slice.
//   a, b : nibble operands
//   cin  : carry into bit 0
//   s    : nibble sum
//   c3   : carry into bit 3 (used for signed overflow)
//   cout : carry out of bit 3
module cla4_slice
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                cout
);
    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic                c1;
    logic                c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened to generate/propagate terms of the slice
    // inputs so no carry depends on another carry.
    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder built around a single 4-bit CLA slice, one nibble per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of nibble_serial_adder_if (operands in,
//                sum/cout/ovf out, valid/ready on each side)
//   state_dbg  : current controller state
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus,
    output state_t                state_dbg
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic               cout_q;
    logic               ovf_q;
    logic               in_ready_q;

    logic               accept;
    logic               last_nib;
    logic [NIBBLE_W-1:0] slice_s;
    logic               slice_c3;
    logic               slice_cout;

    // Operands shift right, so the slice always sees bits [3:0].
    cla4_slice u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (b_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .c3   (slice_c3),
        .cout (slice_cout)
    );

    // New sum nibble enters at the top; after NIBBLES steps nibble 0 has
    // reached the bottom.
    assign acc_next = (acc_q >> NIBBLE_W) | (WIDTH'(slice_s) << (WIDTH - NIBBLE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_nib = (cnt_q == LAST_NIB);
        case (state_q)
            IDLE: begin
                accept = bus.in_valid & in_ready_q;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            // in_ready is registered off the previous state, so it rises
            // one cycle after DONE hands back to IDLE and never overlaps
            // out_valid.
            in_ready_q <= (state_q == IDLE) && !accept;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                carry_q <= bus.cin;
                cnt_q   <= '0;
                acc_q   <= '0;
            end else if (state_q == RUN) begin
                a_q     <= a_q >> NIBBLE_W;
                b_q     <= b_q >> NIBBLE_W;
                carry_q <= slice_cout;
                acc_q   <= acc_next;
                cnt_q   <= cnt_q + CNT_W'(1);
                if (last_nib) begin
                    sum_q  <= acc_next;
                    cout_q <= slice_cout;
                    ovf_q  <= slice_cout ^ slice_c3;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: a WIDTH=16 instance with
// directed and random traffic checked against an arithmetic model, plus
// an exhaustive sweep of a WIDTH=4 instance.
module tb_nibble_serial_adder;
    import nsa_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    nibble_serial_adder_if #(.WIDTH(16)) bus ();
    nibble_serial_adder_if #(.WIDTH(4))  bus4 ();
    state_t st16;
    state_t st4;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (st16)
    );

    nibble_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .state_dbg (st4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cycle);
    endtask

    // {cout, ovf, sum} straight from a + b + cin.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] t;
        logic        v;
        t = {1'b0, a} + {1'b0, b} + 17'(c);
        v = (a[15] == b[15]) && (t[15] != a[15]);
        return {t[16], v, t[15:0]};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + 5'(c);
        v = (a[3] == b[3]) && (t[3] != a[3]);
        return {t[4], v, t[3:0]};
    endfunction

    // Scoreboard for the 16-bit instance.
    logic [17:0] exp_q[$];
    int          acc_q[$];
    bit          prev_valid = 1'b0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
            prev_valid = 1'b0;
            chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_sum",       32'(bus.sum),       32'd0);
            chk("rst_cout",      32'(bus.cout),      32'd0);
            chk("rst_ovf",       32'(bus.ovf),       32'd0);
        end else begin
            chk("ready_valid_excl", 32'(bus.in_ready & bus.out_valid), 32'd0);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_result", $sformatf("sum %0h with no pending operands", bus.sum));
                end else begin
                    chk("result", 32'({bus.cout, bus.ovf, bus.sum}), 32'(exp_q[0]));
                    if (!prev_valid) begin
                        chk("latency", 32'(cycle - acc_q[0]), 32'd5);
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        n_done++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model16(bus.a, bus.b, bus.cin));
                acc_q.push_back(cycle);
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
        int n;
        n = 0;
        bus.a = a;
        bus.b = b;
        bus.cin = c;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) fail("send16_timeout", "in_ready never rose");
        sync();
        bus.in_valid = 1'b0;
    endtask

    // Returns at the first negedge with out_valid high.
    task automatic wait_out16();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) fail("wait_out16_timeout", "out_valid never rose");
    endtask

    task automatic expect16(input string tag, input logic [15:0] s, input logic co, input logic ov);
        chk({tag, "_sum"},  32'(bus.sum),  32'(s));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(co));
        chk({tag, "_ovf"},  32'(bus.ovf),  32'(ov));
    endtask

    initial begin
        int t0;
        int n_before;
        int n;
        logic [3:0] a4;
        logic [3:0] b4;

        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        bus4.in_valid = 1'b0;
        bus4.a = '0;
        bus4.b = '0;
        bus4.cin = 1'b0;
        bus4.out_ready = 1'b1;

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", 32'(st16), 32'(IDLE));
        sync();
        rst_n = 1'b1;
        sync();

        // Basic add with latency
        send16(16'h1234, 16'h4321, 1'b0);
        t0 = cycle;
        wait_out16();
        chk("latency_basic", 32'(cycle - t0), 32'd4);
        expect16("basic", 16'h5555, 1'b0, 1'b0);

        sync();
        send16(16'hFFFF, 16'h0000, 1'b1);
        wait_out16();
        expect16("ripple", 16'h0000, 1'b1, 1'b0);

        sync();
        send16(16'h7FFF, 16'h0001, 1'b0);
        wait_out16();
        expect16("ovf_pos", 16'h8000, 1'b0, 1'b1);

        sync();
        send16(16'h8000, 16'h8000, 1'b0);
        wait_out16();
        expect16("ovf_neg", 16'h0000, 1'b1, 1'b1);

        // Backpressure with ignored operands
        sync();
        bus.out_ready = 1'b0;
        send16(16'h0F0F, 16'h0101, 1'b0);
        wait_out16();
        expect16("bp", 16'h1010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            sync();
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            bus.cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
            expect16("bp_hold", 16'h1010, 1'b0, 1'b0);
        end
        sync();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_ready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        chk("bp_ready_back", 32'(bus.in_ready), 32'd1);

        // Reset in the middle of RUN
        sync();
        send16(16'hFFFF, 16'h0001, 1'b0);
        sync();
        sync();
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_state", 32'(st16), 32'(IDLE));
        sync();
        rst_n = 1'b1;
        sync();
        send16(16'h0001, 16'h0001, 1'b0);
        wait_out16();
        expect16("post_rst", 16'h0002, 1'b0, 1'b0);

        // Random traffic with out_ready gaps
        sync();
        n_before = n_done;
        for (int i = 0; i < 1000; i++) begin
            bus.out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) sync();
            send16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            wait_out16();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sync();
            bus.out_ready = 1'b1;
            sync();
        end
        bus.out_ready = 1'b1;
        repeat (3) sync();
        chk("rand_count", 32'(n_done - n_before), 32'd1000);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // Exhaustive WIDTH=4
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    a4 = 4'(ai);
                    b4 = 4'(bi);
                    bus4.a = a4;
                    bus4.b = b4;
                    bus4.cin = 1'(ci);
                    bus4.in_valid = 1'b1;
                    n = 0;
                    @(negedge clk);
                    while (!bus4.in_ready && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!bus4.in_ready) fail("send4_timeout", "in_ready never rose");
                    sync();
                    bus4.in_valid = 1'b0;
                    n = 0;
                    @(negedge clk);
                    while (!bus4.out_valid && n < 20) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!bus4.out_valid) begin
                        fail("wait_out4_timeout", "out_valid never rose");
                    end else begin
                        chk($sformatf("exh4_%0h_%0h_%0d", a4, b4, ci),
                            32'({bus4.cout, bus4.ovf, bus4.sum}), 32'(model4(a4, b4, 1'(ci))));
                    end
                    sync();
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Sequential wide-operand adder that feeds a 4-bit carry-lookahead slice one nibble per cycle and assembles a WIDTH-bit sum. It sits directly upstream of the 4-bit CLA: it latches wide operands, sequences nibbles into the slice, registers the inter-nibble carry and collects the slice outputs. Operands enter and results leave on valid/ready handshakes. Datapaths that need wide adds but can only afford one 4-bit CLA instance use this block.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived constant; not overridable.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set on a, b and cin is valid.
- in_ready  output  1  block can accept an operand set.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum, cout and ovf are valid.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow: carry into the MSB XOR cout.

## Operation
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b and cin, clear the nibble counter, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, present nibble k (bits 4k+3:4k) of the latched A and B plus the carry register to the slice. Capture the slice sum nibble and load its cout into the carry register. After nibble NIBBLES-1, register sum, cout and ovf, then go to DONE.
  - DONE: out_valid=1. Outputs are held stable. On out_ready, go to IDLE.
- Implementation: operand registers shift right by 4 per RUN cycle; slice sum nibbles shift into the result register from the top. No variable-index muxing is needed.
- Carry register: loaded with cin on accept, updated only in RUN.
- ovf: taken from the slice's carry into bit 3 (c3) and cout on the last nibble.
- in_valid is ignored outside IDLE. Inputs are sampled only on the accept edge; later changes have no effect.
- Reset value of every output: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0. State resets to IDLE; counter, carry and operand registers reset to 0.
- Reset asserted mid-operation (RUN or DONE): abort immediately (asynchronous); the result is discarded. No stale carry or partial sum survives.
- Wrap-around: sum is truncated to WIDTH bits; the overflowing bit appears only on cout.

## Timing
- Accept edge T0 = the edge where in_valid&in_ready.
- RUN occupies cycles T0..T0+NIBBLES-1 (one nibble per cycle).
- out_valid rises at edge T0+NIBBLES, giving a latency of NIBBLES cycles (4 for WIDTH=16).
- out_valid stays high until the edge where out_ready is sampled high. A result is delivered only if out_valid&out_ready.
- in_ready goes high on the edge after the output handshake. There is no back-to-back overlap.
- Minimum issue interval is NIBBLES+2 cycles.
- If out_ready is already high when out_valid rises, DONE lasts exactly one cycle.
- in_ready and out_valid are never high in the same cycle.

## Structure
- Package nsa_pkg contains:
  - State enum: IDLE, RUN, DONE.
  - Constant NIBBLE_W=4.
  - Counter width function clog2(NIBBLES).
- Sub-module cla4_slice: combinational 4-bit carry-lookahead slice.
  - Inputs: a[3:0], b[3:0], cin. Outputs: s[3:0], c3, cout.
  - Full lookahead equations: c1 = g0|p0·cin, c2 = g1|p1·c1 expanded, c3 expanded, cout = g3|p3·c3.
  - One instance only.
- Top level: FSM, counter, shift registers, carry register.

## Test plan
All scenarios use WIDTH=16 unless noted.
- Basic add, no carry: reset, then a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Carry ripple through all nibbles: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1. Also a=0x8000, b=0x8000 → sum=0x0000, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and toggle in_valid with new operands during that time.
  - Required: sum, cout and ovf stable; in_ready=0; the new operands are ignored.
  - After out_ready=1 for one edge: out_valid=0, then in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 nibbles of 0xFFFF+0x0001.
  - During reset, all outputs take their reset values.
  - After release, 0x0001+0x0001, cin=0 → sum=0x0002, cout=0 (no stale carry).
- Random and exhaustive checking:
  - 1000 random operand sets with random out_ready gaps; compare against a+b+cin. ovf must match (a[15]==b[15]) && (sum[15]!=a[15]).
  - Exhaustive 512 combinations on a WIDTH=4 instance.
